// File: rtl/popcount_scheduler_pkg.sv
// Shared definitions for the popcount scheduler.
//   state_t  : controller states (IDLE/ISSUE/WAIT/DONE)
//   wrap_inc : round-robin pointer advance, wrapping at n
package popcount_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/popcount_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req  in  NREQ  request vector
//   ptr  in  IDW   index searched first; search wraps NREQ-1 -> 0
//   en   in  1     when low, no grant is produced
//   gnt  out NREQ  one-hot winner (all zero if none)
//   idx  out IDW   encoded winner index (0 if none)
module rr_arbiter
  import popcount_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    logic           found;
    int             j;
    logic [IDW-1:0] jj;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (en && !found && req[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/popcount_scheduler.sv
// Round-robin scheduler sharing one registered popcount datapath among NREQ requesters.
//   clk, rst           clock, synchronous active-high reset
//   req, req_data      per-requester level request and operand (slot i at [i*DW +: DW])
//   gnt                one-hot grant pulse, issued combinationally in IDLE
//   pc_load, pc_a      datapath load strobe and operand
//   pc_q               datapath result, valid the cycle after pc_load
//   rsp_valid/ready    response handshake; rsp_id and rsp_count held while pending
//   busy               high whenever the controller is not IDLE
module popcount_scheduler
  import popcount_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2,
  parameter int CW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               pc_load,
  output logic [DW-1:0]      pc_a,
  input  logic [CW-1:0]      pc_q,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [CW-1:0]      rsp_count,
  output logic               busy
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_p0;
  logic [IDW-1:0]  win_idx;
  logic [NREQ-1:0] win_gnt;
  logic [DW-1:0]   win_data;
  logic            arb_en;

  // Gating with rst keeps gnt quiet during the reset cycle itself.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .en (arb_en),
    .gnt(win_gnt),
    .idx(win_idx)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_gnt[i]) win_data = req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|win_gnt) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = win_gnt;
    pc_load   = (state == ISSUE);
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Grant edge: operand goes straight into pc_a, which then holds it until the
  // next grant, so it is stable throughout ISSUE and unchanged elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      id_p0     <= '0;
      pc_a      <= '0;
      rsp_id    <= '0;
      rsp_count <= '0;
    end else begin
      if (|win_gnt) begin
        pc_a   <= win_data;
        id_p0  <= win_idx;
        rr_ptr <= IDW'(wrap_inc(int'(win_idx), NREQ));
      end
      // Capture stage: datapath result is valid in WAIT.
      if (state == WAIT) begin
        rsp_count <= pc_q;
        rsp_id    <= id_p0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_scheduler.sv
module tb_popcount_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;
  localparam int CW   = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               pc_load;
  logic [DW-1:0]      pc_a;
  logic [CW-1:0]      pc_q = '0;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [CW-1:0]      rsp_count;
  logic               busy;

  popcount_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .pc_load(pc_load), .pc_a(pc_a), .pc_q(pc_q), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: registered popcount of the loaded operand.
  always @(posedge clk) if (pc_load) pc_q <= CW'($countones(pc_a));

  typedef struct {
    int id;
    int cnt;
    int opnd;
    int gcyc;
  } exp_t;

  exp_t exp_q[$];
  int   gl[$];   // granted ids in order
  int   gc[$];   // grant cycles
  int   rl[$];   // accepted response counts (observed)
  int   ri[$];   // accepted response ids (observed)
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  logic rv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] slot(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // One clock: sample at negedge, score, then let the requester drop a granted req.
  task automatic cycle();
    logic [NREQ-1:0] g;
    int w;
    exp_t e;
    @(negedge clk);
    cyc++;
    g = gnt;
    if (!rst) begin
      if (busy) begin
        chk("gnt_busy", 32'(gnt), 0);
      end else if (|req) begin
        w = winner(req, model_ptr);
        chk("gnt_rr", 32'(gnt), 32'(1) << w);
        e.id = w; e.cnt = $countones(slot(w)); e.opnd = int'(slot(w)); e.gcyc = cyc;
        exp_q.push_back(e);
        gl.push_back(w);
        gc.push_back(cyc);
        model_ptr = (w + 1) % NREQ;
      end else begin
        chk("gnt_idle", 32'(gnt), 0);
      end
      if (pc_load) begin
        chk("load_q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("pc_a", 32'(pc_a), exp_q[$].opnd);
          chk("load_latency", cyc, exp_q[$].gcyc + 1);
        end
      end
      if (rsp_valid) begin
        chk("rsp_q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("rsp_id", 32'(rsp_id), exp_q[0].id);
          chk("rsp_count", 32'(rsp_count), exp_q[0].cnt);
          if (!rv_prev) chk("rsp_latency", cyc, exp_q[0].gcyc + 3);
          if (rsp_ready) begin
            rl.push_back(int'(rsp_count));
            ri.push_back(int'(rsp_id));
            void'(exp_q.pop_front());
          end
        end
      end
      rv_prev = rsp_valid && !rsp_ready;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_ptr = 0;
      rv_prev = 1'b0;
    end else begin
      req = req & ~g;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (gl.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("grant_timeout", gl.size(), n);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    gl.delete(); gc.delete(); rl.delete(); ri.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_pc_load"}, 32'(pc_load), 0);
    chk({tag, "_pc_a"}, 32'(pc_a), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_count"}, 32'(rsp_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n_before;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    #1;
    do_reset();
    check_reset_outputs("reset");

    // Test 1: single request, operand FF
    clear_logs();
    rsp_ready = 1'b1;
    req_data[7:0] = 8'hFF;
    req = 4'b0001;
    wait_grants(1, 10);
    drain(10);
    chk("t1_grant", gl[0], 0);
    chk("t1_rsp_n", rl.size(), 1);
    if (rl.size() > 0) begin
      chk("t1_count", rl[0], 8);
      chk("t1_id", ri[0], 0);
    end

    // Test 2: all request from rr_ptr=0, requester 0 re-requests after its grant
    do_reset();
    clear_logs();
    req_data = {8'h80, 8'hFF, 8'h00, 8'hA5};
    rsp_ready = 1'b1;
    req = 4'b1111;
    wait_grants(1, 10);
    req[0] = 1'b1;
    wait_grants(5, 40);
    drain(10);
    if (gl.size() == 5 && rl.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("t2_order%0d", k), gl[k], (k == 4) ? 0 : k);
        chk($sformatf("t2_count%0d", k), rl[k], (k == 0 || k == 4) ? 4 : (k == 1) ? 0 : (k == 2) ? 8 : 1);
        if (k > 0) chk($sformatf("t2_spacing%0d", k), gc[k] - gc[k-1], 4);
      end
    end else begin
      chk("t2_rsp_n", rl.size(), 5);
    end

    // Test 3: backpressure in DONE with another request pending
    clear_logs();
    req_data[15:8] = 8'h3C;
    rsp_ready = 1'b0;
    req = 4'b0010;
    wait_grants(1, 10);
    req = req | 4'b0100;
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_held", 32'(rsp_valid), 1);
      chk("t3_id_held", 32'(rsp_id), 1);
      chk("t3_count_held", 32'(rsp_count), 4);
      chk("t3_no_gnt", 32'(gnt), 0);
      chk("t3_busy", 32'(busy), 1);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    chk("t3_idle_busy", 32'(busy), 0);
    chk("t3_idle_gnt", 32'(gnt), 32'h4);
    wait_grants(2, 10);
    drain(10);
    chk("t3_rsp_n", rl.size(), 2);

    // Test 4: after a grant to 3, requests 2 and 0 pending -> 0 wins
    clear_logs();
    req = 4'b1000;
    wait_grants(1, 10);
    req = req | 4'b0101;
    wait_grants(3, 30);
    drain(10);
    if (gl.size() == 3) begin
      chk("t4_first", gl[0], 3);
      chk("t4_wrap", gl[1], 0);
      chk("t4_last", gl[2], 2);
    end

    // Test 6: req[1] pulsed for one cycle while busy is never granted
    clear_logs();
    req_data[7:0] = 8'hFF;
    req = 4'b0001;
    wait_grants(1, 10);
    req[1] = 1'b1;
    cycle();
    req[1] = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    chk("t6_grants", gl.size(), 1);
    drain(10);

    // Test 5: reset while in WAIT discards the transaction
    clear_logs();
    req = 4'b0100;
    wait_grants(1, 10);
    cycle();
    rst = 1'b1;
    cycle();
    check_reset_outputs("t5");
    rst = 1'b0;
    n_before = rl.size();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t5_no_valid", 32'(rsp_valid), 0);
    end
    chk("t5_no_rsp", rl.size(), n_before);
    req = 4'b1010;
    wait_grants(2, 10);
    if (gl.size() == 2) chk("t5_after_reset", gl[1], 1);
    drain(10);
    if (ri.size() > 0) begin
      chk("t5_rsp_id", ri[$], 1);
      chk("t5_rsp_count", rl[$], 4);
    end
    req = '0;
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
